// File: rtl/dds_sweep_controller_if.sv
// Config handshake bundle for the DDFS sweep sequencer.
// master: host drives cfg_valid and the sweep words; slave: sequencer returns cfg_ready.
interface dds_sweep_controller_if #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [FTW_W-1:0]   cfg_start_ftw;
    logic [FTW_W-1:0]   cfg_stop_ftw;
    logic [FTW_W-1:0]   cfg_step_ftw;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;

    modport master (
        output cfg_valid, cfg_start_ftw, cfg_stop_ftw,
        output cfg_step_ftw, cfg_dwell, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_start_ftw, cfg_stop_ftw,
        input  cfg_step_ftw, cfg_dwell, cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sweep_controller.sv
// Linear FTW sweep sequencer (single / repeat / up-down) for the DDFS phase accumulator.
// Ports: clk, reset (async high), cfg (config handshake), start/abort in; ftw_out, ftw_valid, acc_clr, step_tick, busy, done out.
module dds_sweep_controller #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    dds_sweep_controller_if.slave cfg,
    input  logic               start,
    input  logic               abort,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_valid,
    output logic               acc_clr,
    output logic               step_tick,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [FTW_W-1:0]   start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [1:0]         mode_r;

    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [FTW_W-1:0]   ftw_n;
    logic               dir_dn, dir_dn_n;
    logic               valid_n, clr_n, tick_n, busy_n, done_n;

    // One extra bit so the add cannot wrap and the subtract exposes a borrow.
    logic [FTW_W:0]     sum, diff;
    logic [FTW_W-1:0]   up_val, dn_val;
    logic               degen;

    assign cfg.cfg_ready = (state == IDLE);

    assign sum    = {1'b0, ftw_out} + {1'b0, step_r};
    assign diff   = {1'b0, ftw_out} - {1'b0, step_r};
    assign up_val = (sum > {1'b0, stop_r}) ? stop_r : sum[FTW_W-1:0];
    assign dn_val = (diff[FTW_W] || diff[FTW_W-1:0] < start_r)
                  ? start_r : diff[FTW_W-1:0];
    assign degen  = (step_r == '0) || (start_r >= stop_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_r <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            dwell_r <= '0;
            mode_r  <= '0;
        end else if (cfg.cfg_valid && state == IDLE) begin
            start_r <= cfg.cfg_start_ftw;
            stop_r  <= cfg.cfg_stop_ftw;
            step_r  <= cfg.cfg_step_ftw;
            dwell_r <= cfg.cfg_dwell;
            mode_r  <= cfg.cfg_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_dn    <= 1'b0;
            ftw_out   <= '0;
            ftw_valid <= 1'b0;
            acc_clr   <= 1'b0;
            step_tick <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dir_dn    <= dir_dn_n;
            ftw_out   <= ftw_n;
            ftw_valid <= valid_n;
            acc_clr   <= clr_n;
            step_tick <= tick_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dir_dn_n = dir_dn;
        ftw_n    = ftw_out;
        valid_n  = ftw_valid;
        busy_n   = busy;
        clr_n    = 1'b0;
        tick_n   = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start && !abort) begin
                    state_n  = RUN;
                    ftw_n    = start_r;
                    cnt_n    = dwell_r;
                    dir_dn_n = 1'b0;
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                    clr_n    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // End of dwell: advance, reload, turn around, or finish.
                    cnt_n  = dwell_r;
                    tick_n = 1'b1;
                    if (degen) begin
                        state_n = DONE;
                    end else if (!dir_dn) begin
                        if (ftw_out != stop_r) begin
                            ftw_n = up_val;
                        end else begin
                            unique case (mode_r)
                                2'd1: begin
                                    ftw_n = start_r;
                                    clr_n = 1'b1;
                                end
                                2'd2: begin
                                    dir_dn_n = 1'b1;
                                    ftw_n    = dn_val;
                                end
                                default: state_n = DONE;
                            endcase
                        end
                    end else if (ftw_out != start_r) begin
                        ftw_n = dn_val;
                    end else begin
                        dir_dn_n = 1'b0;
                        ftw_n    = up_val;
                    end
                    if (state_n == DONE) begin
                        tick_n  = 1'b0;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/dds_sweep_controller.md
Name: dds_sweep_controller

Overview:
Sequencer for the DDFS phase-accumulator datapath. Drives the frequency tuning word (FTW) that sets the triangular and other waveform generators' output frequency. Executes a programmed linear frequency sweep (start, stop, step, dwell) in single, repeat or up-down mode. Provides a config handshake and a start/abort/busy/done control interface to the top-level or host.

Parameters:
FTW_W, 32, tuning word width (bits); matches the phase accumulator width
DWELL_W, 16, dwell counter width (bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config word present
cfg_ready  out  1  config can be accepted; equals (state==IDLE)
cfg_start_ftw  in  FTW_W  first FTW of the sweep
cfg_stop_ftw  in  FTW_W  last FTW of the sweep; must be >= start
cfg_step_ftw  in  FTW_W  FTW increment per step
cfg_dwell  in  DWELL_W  hold each FTW for dwell+1 cycles
cfg_mode  in  2  0 single, 1 repeat, 2 up-down, 3 treated as single
start  in  1  begin sweep (level sampled; acted on in IDLE only)
abort  in  1  stop immediately
ftw_out  out  FTW_W  tuning word to the phase accumulator
ftw_valid  out  1  ftw_out is live (high while busy)
acc_clr  out  1  one-cycle pulse that clears the phase accumulator
step_tick  out  1  one-cycle pulse on every ftw_out change after the first
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on normal sweep completion

Behaviour:
- Reset (async): state IDLE; all registered outputs 0; config shadow registers 0; direction = up.
- Config: accepted on clk edge with cfg_valid & cfg_ready; all cfg_* latched into shadow registers. Ignored while busy.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE to RUN when start=1 and abort=0. Next cycle: ftw_out=start_ftw, ftw_valid=1, busy=1, acc_clr=1 for that cycle only. Dwell counter loads dwell; direction = up.
- RUN: counter decrements each cycle. On the cycle it reads 0, the end-of-dwell action applies at the next edge, so each FTW is held exactly dwell+1 cycles.
- End-of-dwell, up direction:
  - ftw_out != stop: ftw_out = min(ftw_out+step, stop). Compute in FTW_W+1 bits; never wraps.
  - ftw_out == stop: single goes to DONE; repeat sets ftw_out=start with an acc_clr pulse; up-down flips to down and sets ftw_out = max(ftw_out-step, start).
- End-of-dwell, down direction:
  - ftw_out != start: ftw_out = max(ftw_out-step, start). Computed with borrow detection; never underflows.
  - ftw_out == start: flip to up, ftw_out = min(start+step, stop).
- step_tick=1 in the same cycle as each ftw_out update inside RUN. It is not asserted on the initial load.
- Degenerate cases: step==0, or start>=stop, means the first end-of-dwell goes to DONE in every mode.
- DONE (one cycle): done=1, busy=0, ftw_valid=0, ftw_out holds the last value; next state IDLE.
- abort: from any state, next cycle is IDLE with busy=0, ftw_valid=0, ftw_out held, no done pulse. abort has priority over start and over the end-of-dwell action.
- start while busy: ignored.
- start without any prior config: zero config gives ftw_out=0 for 1 cycle, then done.
- Reset asserted mid-sweep: immediate return to reset values. Config shadows are cleared.

Test Plan:
- Single sweep, start=100, stop=130, step=10, dwell=2, mode 0: ftw_out = 100,110,120,130, each for 3 cycles. acc_clr once, at cycle 1. step_tick 3 times. busy 12 cycles; done at cycle 13 after start sampled.
- Clamp and mode 2, start=0, stop=25, step=10, dwell=0: ftw_out = 0,10,20,25,15,5,0,10,... one value per cycle, busy stays high.
- Overflow guard, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, mode 1: 0xFFFFFFF0, 0xFFFFFFFF, then 0xFFFFFFF0 with an acc_clr pulse. Never 0x00000000.
- Abort mid-dwell while ftw_out=110: next cycle busy=0, ftw_valid=0, ftw_out=110, done never pulses. New start restarts at 100.
- cfg_valid with new values while busy: no effect on the running sweep, cfg_ready=0. Degenerate step=0 (dwell=3): done after 4 cycles.
- Async reset asserted between clock edges mid-sweep: outputs 0 immediately; cfg_ready=1 after release.
